// File: rtl/multi_input_buff.sv
// multi_input_buff: synchronised NCHAN-line serial capture into NDATA-bit words.
// Optional macro MULTI_INPUT_BUFF_SYNC3_EN selects a 3-flop synchroniser (2 by default).
module multi_input_buff #(
  parameter int NCHAN = 4,
  parameter int NDATA = 128,
  parameter logic [NCHAN-1:0] INIT_MASK = NCHAN'(1),
  localparam int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCHAN-1:0]       din,
  input  logic                   ena,
  input  logic                   start,
  input  logic [NDATA_LOG-1:0]   len,
  output logic [NCHAN*NDATA-1:0] dout,
  output logic                   busy,
  output logic                   done,
  output logic [NDATA_LOG-1:0]   cnt
);

`ifdef MULTI_INPUT_BUFF_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  typedef enum logic [1:0] {
    IDLE,
    CAP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_N*NCHAN-1:0] sync_r;
  logic [NCHAN-1:0]        sync_q;
  logic [NDATA_LOG-1:0]    cnt_q;
  logic [NDATA_LOG-1:0]    len_q;
  logic [NDATA_LOG-1:0]    lenm1;
  logic                    last;
  logic                    wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[(SYNC_N-1)*NCHAN-1:0], din};
    end
  end

  assign sync_q = sync_r[SYNC_N*NCHAN-1 -: NCHAN];

  // len_q of 0 wraps to all ones, i.e. the final write lands at NDATA-1
  assign lenm1 = len_q - 1'b1;
  assign last  = (cnt_q == lenm1);
  assign wr    = (state_q == CAP) && ena;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: ;
      CAP: begin
        busy = 1'b1;
        if (ena && last) state_d = DONE;
      end
      DONE: done = 1'b1;
      default: state_d = IDLE;
    endcase
    if (start) state_d = CAP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      len_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
      len_q <= len;
    end else if (wr) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic [NDATA-1:0] word_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        word_q <= {NDATA{INIT_MASK[c]}};
      end else if (start) begin
        word_q <= {NDATA{INIT_MASK[c]}};
      end else if (wr) begin
        word_q[cnt_q] <= sync_q[c];
      end
    end

    assign dout[c*NDATA +: NDATA] = word_q;
  end

endmodule

// File: tb/tb_multi_input_buff.sv
// tb_multi_input_buff: directed checks of multi_input_buff capture, restart and reset.
// Define MULTI_INPUT_BUFF_SYNC3_EN for both files to exercise the 3-flop build.
module tb_multi_input_buff;

  localparam int NCHAN = 4;
  localparam int NDATA = 128;
  localparam int NL    = 7;
`ifdef MULTI_INPUT_BUFF_SYNC3_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  localparam logic [NDATA-1:0] ONES = '1;
  localparam logic [NDATA-1:0] ZERO = '0;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCHAN-1:0]       din;
  logic                   ena;
  logic                   start;
  logic [NL-1:0]          len;
  logic [NCHAN*NDATA-1:0] dout;
  logic                   busy;
  logic                   done;
  logic [NL-1:0]          cnt;

  int n_cmp = 0;
  int n_bad = 0;

  multi_input_buff #(
    .NCHAN(NCHAN),
    .NDATA(NDATA),
    .INIT_MASK(4'b0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .ena(ena),
    .start(start),
    .len(len),
    .dout(dout),
    .busy(busy),
    .done(done),
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [NDATA-1:0] word(input int c);
    return dout[c*NDATA +: NDATA];
  endfunction

  task automatic chk(input string tag,
                     input logic [NDATA-1:0] obs,
                     input logic [NDATA-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b0;
    din   = '0;
    ena   = 1'b0;
    start = 1'b0;
    len   = '0;

    // reset values while din toggles
    for (int i = 0; i < 4; i++) begin
      din = 4'(i * 5);
      tick(1);
    end
    chk("rst_ch0", word(0), ONES);
    chk("rst_ch1", word(1), ZERO);
    chk("rst_ch2", word(2), ZERO);
    chk("rst_ch3", word(3), ZERO);
    chk_s("rst_busy", int'(busy), 0);
    chk_s("rst_done", int'(done), 0);
    chk_s("rst_cnt", int'(cnt), 0);

    // full capture, len=0 -> 128 samples
    rst = 1'b1;
    din = 4'b1010;
    tick(LAT + 1);
    start = 1'b1;
    len   = '0;
    ena   = 1'b1;
    tick(1);
    chk_s("full_busy0", int'(busy), 1);
    chk_s("full_cnt0", int'(cnt), 0);
    start = 1'b0;
    tick(127);
    chk_s("full_done127", int'(done), 0);
    chk_s("full_cnt127", int'(cnt), 127);
    tick(1);
    chk_s("full_done", int'(done), 1);
    chk_s("full_busy", int'(busy), 0);
    chk_s("full_cnt", int'(cnt), 0);
    chk("full_ch0", word(0), ZERO);
    chk("full_ch1", word(1), ONES);
    chk("full_ch2", word(2), ZERO);
    chk("full_ch3", word(3), ONES);

    // short capture with gapped strobes
    ena = 1'b0;
    din = 4'b0110;
    tick(LAT + 1);
    start = 1'b1;
    len   = 7'd5;
    ena   = 1'b1;
    tick(1);
    chk_s("short_nowr", int'(cnt), 0);
    chk_s("short_done0", int'(done), 0);
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ena = ~i[0];
      tick(1);
    end
    chk_s("short_done4", int'(done), 0);
    chk_s("short_cnt4", int'(cnt), 4);
    ena = 1'b1;
    tick(1);
    chk_s("short_done5", int'(done), 1);
    chk("short_ch0", word(0), ~128'h1F);
    chk("short_ch1", word(1), 128'h1F);
    chk("short_ch2", word(2), 128'h1F);
    chk("short_ch3", word(3), ZERO);
    ena = 1'b0;
    din = 4'b1001;
    tick(2);
    chk_s("short_hold_done", int'(done), 1);
    chk("short_hold_ch1", word(1), 128'h1F);

    // restart mid-capture
    din = 4'b0110;
    tick(LAT + 1);
    start = 1'b1;
    len   = 7'd8;
    ena   = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    chk_s("rs_cnt3", int'(cnt), 3);
    chk("rs_ch1_3", word(1), 128'h7);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk_s("rs_cnt0", int'(cnt), 0);
    chk_s("rs_busy", int'(busy), 1);
    chk("rs_ch1_clr", word(1), ZERO);
    chk("rs_ch0_clr", word(0), ONES);
    tick(7);
    chk_s("rs_done7", int'(done), 0);
    chk_s("rs_cnt7", int'(cnt), 7);
    tick(1);
    chk_s("rs_done8", int'(done), 1);
    chk("rs_ch1", word(1), 128'hFF);
    chk("rs_ch0", word(0), ~128'hFF);

    // start on the completing strobe wins
    start = 1'b1;
    len   = 7'd2;
    tick(1);
    start = 1'b0;
    tick(1);
    chk_s("sw_cnt1", int'(cnt), 1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    len   = '0;
    chk_s("sw_busy", int'(busy), 1);
    chk_s("sw_done", int'(done), 0);
    chk_s("sw_cnt", int'(cnt), 0);
    chk("sw_ch2", word(2), ZERO);
    tick(2);
    chk_s("sw_done2", int'(done), 1);
    chk("sw_ch2_fin", word(2), 128'h3);

    // reset mid-capture
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(10);
    chk_s("rm_cnt10", int'(cnt), 10);
    rst = 1'b0;
    #1;
    chk_s("rm_cnt", int'(cnt), 0);
    chk_s("rm_busy", int'(busy), 0);
    chk("rm_ch0", word(0), ONES);
    chk("rm_ch1", word(1), ZERO);
    chk("rm_ch2", word(2), ZERO);
    tick(1);
    rst = 1'b1;
    tick(1);
    chk_s("rm_idle_busy", int'(busy), 0);
    chk_s("rm_idle_done", int'(done), 0);
    chk("rm_idle_ch0", word(0), ONES);

    // synchroniser latency: one-cycle pulse on channel 2
    din = '0;
    ena = 1'b1;
    tick(LAT + 1);
    start = 1'b1;
    len   = '0;
    tick(1);
    start = 1'b0;
    din   = 4'b0100;
    tick(1);
    din = '0;
    tick(126);
    chk_s("lat_done127", int'(done), 0);
    tick(1);
    chk_s("lat_done", int'(done), 1);
    chk("lat_ch2", word(2), ZERO | (128'h1 << LAT));
    chk("lat_ch1", word(1), ZERO);
    chk("lat_ch0", word(0), ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_input_buff.md
# multi_input_buff

Parametrised multi-channel serial-capture buffer; successor to the fixed four-channel input buffer. Synchronises NCHAN asynchronous serial lines, then on a start request captures a programmable number of strobed samples per channel into parallel NDATA-bit registers. Reports completion with a held done flag. Sits between the pad-level serial inputs and the correlation/decision logic that consumes the reference and signal words.

## Interface
- NCHAN, 4: number of serial channels; 1..16.
- NDATA, 128: capture depth in bits per channel; power of two, ≥4.
- INIT_MASK, 1 (NCHAN bits): bit c set → channel c clears to all ones; clear → all zeros. Default: channel 0 is the reference, pre-filled with ones.
- NDATA_LOG: localparam, $clog2(NDATA).
- clk  in  1  single system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  NCHAN  raw asynchronous serial inputs, bit c = channel c.
- ena  in  1  sample strobe, active high; one capture per strobed cycle.
- start  in  1  capture request, sampled every cycle.
- len  in  NDATA_LOG  samples to capture; 0 means NDATA; latched on accepted start.
- dout  out  NCHAN*NDATA  channel c at dout[c*NDATA +: NDATA].
- busy  out  1  high while capturing.
- done  out  1  high from capture completion until next start or reset.
- cnt  out  NDATA_LOG  current write index.

## Operation
- Synchroniser: per-channel shift chain, 2 flops by default, clocked every cycle regardless of ena. Captured value is the last stage (sync_q).
- FSM states: IDLE, CAP, DONE.
  - IDLE: busy=0, done=0. start=1 → CAP.
  - CAP: busy=1. Each cycle with ena=1: for every c, dout[c*NDATA+cnt] <= sync_q[c]; cnt <= cnt+1. Cycles with ena=0 hold everything.
  - The strobed write at cnt == len_q-1 → DONE. len_q=0 means the write at cnt == NDATA-1; cnt wraps to 0.
  - DONE: busy=0, done=1, dout held. start=1 → CAP.
- Accepted start, in any state including CAP (restart/abort): every channel cleared to its INIT_MASK value; cnt=0; len_q=len. No sample is written in the start cycle even if ena=1.
- Bits at index ≥ len_q keep their init value.
- Bit order: first captured sample at bit 0 of each channel word, i.e. LSB first.

## Timing
- Reset values: dout channel c = {NDATA{INIT_MASK[c]}}; sync flops 0; cnt=0; len_q=0; busy=0; done=0; state IDLE.
- Reset asserted mid-capture aborts immediately to the reset values above. There is no partial-data retention.
- din→sync_q latency: 2 clk (3 with the option below).
- start at edge k → busy=1 after edge k; earliest sample written at edge k+1.
- For an uninterrupted ena=1 run after start, done rises after edge k+L, where L = len_q (NDATA if 0). busy falls on the same edge.
- start asserted on the same edge that completes a capture: start wins. The final write is discarded, the buffer is cleared, and the FSM stays in CAP with done=0.
- dout is stable whenever done=1.

## Configuration
- MULTI_INPUT_BUFF_SYNC3_EN defined: synchroniser is 3 flops per channel; din→sync_q latency is 3 clk.
- Undefined: 2 flops, latency 2 clk.
- FSM, capture and handshake behaviour are identical in both builds.

## Test plan
- Reset values, NCHAN=4, NDATA=128, INIT_MASK=4'b0001: hold rst=0 and toggle din → dout[127:0] all ones, other channels all zeros, busy=0, done=0.
- Full capture, len=0, ena=1 continuous, din=4'b1010 static: start, then wait 128 clk → done=1; channel 1 and channel 3 words all ones, channel 0 and channel 2 words all zeros, cnt=0.
- Short capture with gaps, len=5, ena toggling 1,0,1,0,…: start → done after exactly 5 strobes; bits [4:0] written; bits [127:5] equal init values.
- Restart mid-capture: start with len=8; after 3 strobes assert start again → buffers re-cleared, cnt=0; done only after 8 further strobes.
- Reset mid-capture: rst=0 after 10 strobes → immediate reset values; after rst=1, state IDLE.
- Latency check, both builds: single-cycle din pulse on channel 2 lands at the bit index predicted by the 2-clk latency (3-clk with MULTI_INPUT_BUFF_SYNC3_EN).
